capture_trig_ctrl: RTL

- Capture sequencer and trigger detector, directly upstream of the SRAM window address counter.
- Generates the counter-enable pair (pre-trigger fill and post-arm) and a sticky trigger-event level that gate address counting and window counting in the next stage.
- Consumes that stage's Write_Ready to close the capture.
- Trigger is a level-crossing detector on the sampled ADC stream, qualified by a decimation strobe.

---
 rtl/capture_trig_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/capture_trig_ctrl.sv
// capture_trig_ctrl: capture sequencer and level-crossing trigger detector.
// It sits in front of the SRAM window address counter. It drives that stage's
// two count enables and a sticky trigger level, and it uses the stage's
// WRITE_READY flag to close the capture.
//
// Optional feature: define CAPTURE_AUTO_TRIG_EN to build the ARMED-state
// auto-trigger timeout counter. In the default build AUTO_TIMEOUT is ignored.
//
// Ports:
//   CLK, RST            clock and asynchronous active-low reset
//   START               level input; a rising edge arms a capture, low aborts
//   SMPL_EN             sample strobe that qualifies all counting
//   ADC_DATA            current sample
//   TRIG_LEVEL          unsigned trigger threshold
//   TRIG_EDGE           0 = rising crossing, 1 = falling crossing
//   FORCE_TRIG          host force-trigger, honoured only in ARMED
//   PRETRIG_DATA        number of samples stored before the trigger arms
//   AUTO_TIMEOUT        ARMED samples before an auto-trigger (0 = off)
//   WRITE_READY         capture-complete flag from the window counter
//   CNT_EN_0/CNT_EN_1   pre-trigger/armed and armed/post count enables
//   TRIG_EVENT          sticky trigger-occurred level
//   AUTO_TRIGGED        trigger came from force/auto, not from a crossing
//   BUSY                capture in progress (PRETRIG, ARMED, POST)
//   STATE               encoded FSM state
module capture_trig_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 18,
  parameter int unsigned TW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          SMPL_EN,
  input  logic [DW-1:0] ADC_DATA,
  input  logic [DW-1:0] TRIG_LEVEL,
  input  logic          TRIG_EDGE,
  input  logic          FORCE_TRIG,
  input  logic [CW-1:0] PRETRIG_DATA,
  input  logic [TW-1:0] AUTO_TIMEOUT,
  input  logic          WRITE_READY,
  output logic          CNT_EN_0,
  output logic          CNT_EN_1,
  output logic          TRIG_EVENT,
  output logic          AUTO_TRIGGED,
  output logic          BUSY,
  output logic [2:0]    STATE
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPretrig = 3'd1,
    StArmed   = 3'd2,
    StPost    = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic          trig_q, trig_d;
  logic          auto_q, auto_d;
  logic          start_q;
  logic          en0_q, en1_q, busy_q;

  logic          start_rise;
  logic          crossing;
  logic          hit;
  logic          auto_fire;
  logic          force_any;

  assign start_rise = START & ~start_q;

  assign crossing = TRIG_EDGE ? ((prev_q >= TRIG_LEVEL) && (ADC_DATA <  TRIG_LEVEL))
                              : ((prev_q <  TRIG_LEVEL) && (ADC_DATA >= TRIG_LEVEL));
  // Only a crossing between two real samples counts; an already-past level does not.
  assign hit       = SMPL_EN & prev_valid_q & crossing;
  assign force_any = FORCE_TRIG | auto_fire;

`ifdef CAPTURE_AUTO_TRIG_EN
  logic [TW-1:0] tcnt_q, tcnt_d;

  // Held at zero outside ARMED so it is clear on every entry; saturates at all-ones.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q != StArmed) begin
      tcnt_d = '0;
    end else if (SMPL_EN && (tcnt_q != '1)) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Fires on the strobe that brings the count to the timeout, same timing as FORCE_TRIG.
  assign auto_fire = (state_q == StArmed) && (AUTO_TIMEOUT != '0) && (tcnt_d == AUTO_TIMEOUT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  logic unused_auto_timeout;
  assign unused_auto_timeout = ^AUTO_TIMEOUT;
  assign auto_fire           = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    trig_d       = trig_q;
    auto_d       = auto_q;

    if (((state_q == StPretrig) || (state_q == StArmed)) && SMPL_EN) begin
      prev_d       = ADC_DATA;
      prev_valid_d = 1'b1;
    end

    if (!START) begin
      // Abort or normal release from DONE: leave IDLE with clean flags.
      state_d = StIdle;
      trig_d  = 1'b0;
      auto_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_rise) begin
            state_d      = StPretrig;
            cnt_d        = '0;
            prev_valid_d = 1'b0;
            trig_d       = 1'b0;
            auto_d       = 1'b0;
          end
        end
        StPretrig: begin
          // Counting stops at equality, so the counter can never wrap.
          if (cnt_q == PRETRIG_DATA) begin
            state_d = StArmed;
          end else if (SMPL_EN) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StArmed: begin
          if (hit || force_any) begin
            state_d = StPost;
            trig_d  = 1'b1;
            auto_d  = ~hit;  // a real crossing takes priority over force
          end
        end
        StPost: begin
          if (WRITE_READY) begin
            state_d = StDone;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_q       <= 1'b0;
      auto_q       <= 1'b0;
      start_q      <= 1'b0;
      en0_q        <= 1'b0;
      en1_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      trig_q       <= trig_d;
      auto_q       <= auto_d;
      start_q      <= START;
      en0_q        <= (state_d == StPretrig) || (state_d == StArmed);
      en1_q        <= (state_d == StArmed)   || (state_d == StPost);
      busy_q       <= (state_d == StPretrig) || (state_d == StArmed) || (state_d == StPost);
    end
  end

  assign CNT_EN_0     = en0_q;
  assign CNT_EN_1     = en1_q;
  assign TRIG_EVENT   = trig_q;
  assign AUTO_TRIGGED = auto_q;
  assign BUSY         = busy_q;
  assign STATE        = state_q;

endmodule
